// File: rtl/vga_pkg.sv
// Shared VGA 640x480@60 timing constants, datatypes and colour helper.
package vga_pkg;

    localparam int unsigned CNT_W = 11;
    typedef logic [CNT_W-1:0] cnt_t;

    // Horizontal timing, in pixels
    localparam cnt_t H_ACTIVE     = 11'd640;
    localparam cnt_t H_FRONT      = 11'd16;
    localparam cnt_t H_SYNC       = 11'd96;
    localparam cnt_t H_BACK       = 11'd48;
    localparam cnt_t H_TOTAL      = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam cnt_t H_MAX        = H_TOTAL - 11'd1;
    localparam cnt_t H_SYNC_START = H_ACTIVE + H_FRONT;
    localparam cnt_t H_SYNC_END   = H_SYNC_START + H_SYNC;

    // Vertical timing, in lines
    localparam cnt_t V_ACTIVE     = 11'd480;
    localparam cnt_t V_FRONT      = 11'd10;
    localparam cnt_t V_SYNC       = 11'd2;
    localparam cnt_t V_BACK       = 11'd33;
    localparam cnt_t V_TOTAL      = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam cnt_t V_MAX        = V_TOTAL - 11'd1;
    localparam cnt_t V_SYNC_START = V_ACTIVE + V_FRONT;
    localparam cnt_t V_SYNC_END   = V_SYNC_START + V_SYNC;

    // 4-bit-per-channel DAC drive
    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } dac_rgb_t;

    // Active-high timing flags; all-zero means "no sync, blanked",
    // so a cleared delay line naturally yields idle outputs.
    typedef struct packed {
        logic hsync_act;
        logic vsync_act;
        logic active;
    } sync_flags_t;

    localparam int unsigned SYNC_FLAGS_W = $bits(sync_flags_t);

    // RRRGGGBB -> 4:4:4 by replicating the MSBs into the new LSBs
    function automatic dac_rgb_t expand_rgb332(input logic [7:0] rgb);
        dac_rgb_t c;
        c.r = {rgb[7:5], rgb[7]};
        c.g = {rgb[4:2], rgb[4]};
        c.b = {rgb[1:0], rgb[1:0]};
        return c;
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Pixel-rate shift register used to align timing flags with the colour pipe.
module vga_delay_line #(
    parameter int unsigned DEPTH = 1,
    parameter int unsigned WIDTH = 3
) (
    input  logic             i_clk,
    input  logic             i_resetN,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    generate
        if (DEPTH == 0) begin : g_bypass
            logic w_unused;
            assign w_unused = &{1'b0, i_clk, i_resetN, i_en};
            assign o_data   = i_data;
        end else begin : g_pipe
            logic [WIDTH-1:0] r_pipe [DEPTH];

            // Advance one stage per pixel period; cleared to all-zero on reset
            always_ff @(posedge i_clk or negedge i_resetN) begin
                if (!i_resetN) begin
                    for (int unsigned i = 0; i < DEPTH; i++) begin
                        r_pipe[i] <= '0;
                    end
                end else if (i_en) begin
                    r_pipe[0] <= i_data;
                    for (int unsigned i = 1; i < DEPTH; i++) begin
                        r_pipe[i] <= r_pipe[i-1];
                    end
                end
            end

            assign o_data = r_pipe[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_pixel_driver.sv
// VGA 640x480 timing generator and DAC output stage. Counters are presented
// to the pixel pipeline; sync/blank are delayed PIPE_DELAY pixels to meet the
// returning RGB_in, then everything is registered once more at pixel rate.
module vga_pixel_driver
    import vga_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 2,
    parameter int unsigned PIPE_DELAY = 1
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic [7:0]  RGB_in,
    output logic [10:0] pixelX,
    output logic [10:0] pixelY,
    output logic        startOfFrame,
    output logic        pixelEn,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        hsync,
    output logic        vsync,
    output logic        blankN
);

    logic        w_pix_en;
    logic        w_first_phase;
    cnt_t        r_x;
    cnt_t        r_y;
    sync_flags_t w_raw;
    sync_flags_t w_dly;
    dac_rgb_t    w_rgb;
    logic [3:0]  r_r;
    logic [3:0]  r_g;
    logic [3:0]  r_b;
    logic        r_hs;
    logic        r_vs;
    logic        r_bn;

    // Pixel enable: gated by resetN so it reads 0 while held in reset
    generate
        if (CLK_DIV == 1) begin : g_div1
            assign w_pix_en      = resetN;
            assign w_first_phase = 1'b1;
        end else begin : g_div2
            logic r_div;

            // Toggle every clk; low phase first after release
            always_ff @(posedge clk or negedge resetN) begin
                if (!resetN) begin
                    r_div <= 1'b0;
                end else begin
                    r_div <= ~r_div;
                end
            end

            assign w_pix_en      = r_div;
            assign w_first_phase = ~r_div;
        end
    endgenerate

    // Raster counters: X wraps at end of line, Y advances on X wrap
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_x <= '0;
            r_y <= '0;
        end else if (w_pix_en) begin
            if (r_x == H_MAX) begin
                r_x <= '0;
                if (r_y == V_MAX) begin
                    r_y <= '0;
                end else begin
                    r_y <= r_y + cnt_t'(1);
                end
            end else begin
                r_x <= r_x + cnt_t'(1);
            end
        end
    end

    // Timing flags for the pixel currently presented on the counters
    always_comb begin
        w_raw           = '0;
        w_raw.hsync_act = (r_x >= H_SYNC_START) && (r_x < H_SYNC_END);
        w_raw.vsync_act = (r_y >= V_SYNC_START) && (r_y < V_SYNC_END);
        w_raw.active    = (r_x < H_ACTIVE) && (r_y < V_ACTIVE);
    end

    vga_delay_line #(
        .DEPTH (PIPE_DELAY),
        .WIDTH (SYNC_FLAGS_W)
    ) u_delay (
        .i_clk    (clk),
        .i_resetN (resetN),
        .i_en     (w_pix_en),
        .i_data   (w_raw),
        .o_data   (w_dly)
    );

    assign w_rgb = expand_rgb332(RGB_in);

    // Output register stage, updated once per pixel; colour forced dark in blanking
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_r  <= '0;
            r_g  <= '0;
            r_b  <= '0;
            r_hs <= 1'b1;
            r_vs <= 1'b1;
            r_bn <= 1'b0;
        end else if (w_pix_en) begin
            r_hs <= ~w_dly.hsync_act;
            r_vs <= ~w_dly.vsync_act;
            r_bn <= w_dly.active;
            if (w_dly.active) begin
                r_r <= w_rgb.r;
                r_g <= w_rgb.g;
                r_b <= w_rgb.b;
            end else begin
                r_r <= '0;
                r_g <= '0;
                r_b <= '0;
            end
        end
    end

    assign pixelX       = r_x;
    assign pixelY       = r_y;
    assign pixelEn      = w_pix_en;
    assign startOfFrame = resetN && (r_x == '0) && (r_y == '0) && w_first_phase;
    assign vga_r        = r_r;
    assign vga_g        = r_g;
    assign vga_b        = r_b;
    assign hsync        = r_hs;
    assign vsync        = r_vs;
    assign blankN       = r_bn;

endmodule

// File: tb/tb_vga_pixel_driver.sv
// Self-checking bench: two instances (CLK_DIV=2/PIPE_DELAY=2 and
// CLK_DIV=1/PIPE_DELAY=0) compared cycle by cycle against a raster model
// computed from the pixel index since reset release.
module tb_vga_pixel_driver;

    localparam int DIV_A = 2;
    localparam int DLY_A = 2;
    localparam int DIV_B = 1;
    localparam int DLY_B = 0;
    localparam int TAB_N = 8192;
    localparam int RUN_K = 5400;
    localparam int POST_K = 1800;

    typedef struct packed {
        logic        pix_en;
        logic        sof;
        logic [10:0] x;
        logic [10:0] y;
        logic [3:0]  r;
        logic [3:0]  g;
        logic [3:0]  b;
        logic        hs;
        logic        vs;
        logic        bn;
    } obs_t;

    typedef struct {
        logic [7:0] rgb;
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } vec_t;

    logic        clk = 1'b0;
    logic        rstA_n = 1'b0;
    logic        rstB_n = 1'b0;
    logic [7:0]  rgbA = '0;
    logic [7:0]  rgbB = '0;

    logic [10:0] xA, yA, xB, yB;
    logic        sofA, sofB, enA, enB, hsA, hsB, vsA, vsB, bnA, bnB;
    logic [3:0]  rA, gA, bA, rB, gB, bB;

    obs_t obsA, obsB;
    obs_t RST_OBS;

    logic [7:0] tab [TAB_N];
    vec_t       vecs [6];

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    always #5 clk = ~clk;

    vga_pixel_driver #(.CLK_DIV(DIV_A), .PIPE_DELAY(DLY_A)) u_dut_a (
        .clk(clk), .resetN(rstA_n), .RGB_in(rgbA),
        .pixelX(xA), .pixelY(yA), .startOfFrame(sofA), .pixelEn(enA),
        .vga_r(rA), .vga_g(gA), .vga_b(bA),
        .hsync(hsA), .vsync(vsA), .blankN(bnA)
    );

    vga_pixel_driver #(.CLK_DIV(DIV_B), .PIPE_DELAY(DLY_B)) u_dut_b (
        .clk(clk), .resetN(rstB_n), .RGB_in(rgbB),
        .pixelX(xB), .pixelY(yB), .startOfFrame(sofB), .pixelEn(enB),
        .vga_r(rB), .vga_g(gB), .vga_b(bB),
        .hsync(hsB), .vsync(vsB), .blankN(bnB)
    );

    assign obsA = {enA, sofA, xA, yA, rA, gA, bA, hsA, vsA, bnA};
    assign obsB = {enB, sofB, xB, yB, rB, gB, bB, hsB, vsB, bnB};

    function automatic string fmt(input obs_t o);
        return $sformatf("pe=%0b sof=%0b x=%0d y=%0d r=%h g=%h b=%h hs=%0b vs=%0b bn=%0b",
                         o.pix_en, o.sof, o.x, o.y, o.r, o.g, o.b, o.hs, o.vs, o.bn);
    endfunction

    task automatic check_obs(input string name, input obs_t act, input obs_t exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got {%s} expected {%s}", name, fmt(act), fmt(exp));
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Behavioural raster model. k = clk cycles since release (sampled before
    // the (k+1)-th rising edge); DAC outputs show pixel n-1-dly.
    function automatic obs_t model(input int div, input int dly, input int k);
        obs_t e;
        int n, p, xp, yp, c, rv, gv, bv;
        n = k / div;
        e.pix_en = (div == 1) ? 1'b1 : 1'(k % 2);
        e.x   = 11'(n % 800);
        e.y   = 11'((n / 800) % 525);
        e.sof = ((n % 420000) == 0) && ((k % div) == 0);
        p = n - 1 - dly;
        if (p < 0) begin
            e.r = '0; e.g = '0; e.b = '0;
            e.hs = 1'b1; e.vs = 1'b1; e.bn = 1'b0;
        end else begin
            xp = p % 800;
            yp = (p / 800) % 525;
            e.hs = !(xp >= 656 && xp < 752);
            e.vs = !(yp >= 490 && yp < 492);
            e.bn = (xp < 640) && (yp < 480);
            c  = int'(tab[p]);
            rv = c / 32;
            gv = (c / 4) % 8;
            bv = c % 4;
            e.r = e.bn ? 4'(rv * 2 + rv / 4) : 4'd0;
            e.g = e.bn ? 4'(gv * 2 + gv / 4) : 4'd0;
            e.b = e.bn ? 4'(bv * 5)          : 4'd0;
        end
        return e;
    endfunction

    // Colour for the pixel that the pipe returns dly pixels after presentation
    function automatic logic [7:0] drive_rgb(input int div, input int dly, input int k);
        int idx;
        idx = k / div - dly;
        if (idx < 0) return 8'($urandom);
        return tab[idx];
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int hs_low_cnt, bn_hi_cnt, first_hs_x, rise_x, rise_rgb;
        bit rise_found;
        logic prev_bnA;

        RST_OBS = '{pix_en:1'b0, sof:1'b0, x:11'd0, y:11'd0, r:4'd0, g:4'd0, b:4'd0,
                    hs:1'b1, vs:1'b1, bn:1'b0};

        vecs[0] = '{8'hFF,        4'hF, 4'hF, 4'hF};
        vecs[1] = '{8'b100_010_01, 4'h9, 4'h4, 4'h5};
        vecs[2] = '{8'h00,        4'h0, 4'h0, 4'h0};
        vecs[3] = '{8'b011_101_10, 4'h6, 4'hB, 4'hA};
        vecs[4] = '{8'b111_000_11, 4'hF, 4'h0, 4'hF};
        vecs[5] = '{8'b001_110_00, 4'h2, 4'hD, 4'h0};

        for (int i = 0; i < TAB_N; i++) tab[i] = 8'($urandom);
        tab[0]    = 8'hFF;
        tab[800]  = 8'hFF;
        tab[1600] = 8'hFF;

        // ---- reset values while held in reset ----
        repeat (3) @(negedge clk);
        check_obs("rst_A", obsA, RST_OBS);
        check_obs("rst_B", obsB, RST_OBS);
        @(negedge clk);
        rgbA = 8'hFF;
        rgbB = 8'hFF;
        #1;
        check_obs("rst_A_rgb", obsA, RST_OBS);
        check_obs("rst_B_rgb", obsB, RST_OBS);

        // ---- colour expansion table on instance B, first active pixels ----
        @(negedge clk);
        rstB_n = 1'b1;
        rgbB   = vecs[0].rgb;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check_int($sformatf("colour[%0d]", i), int'({rB, gB, bB}),
                      int'({vecs[i].r, vecs[i].g, vecs[i].b}));
            if (i < 5) rgbB = vecs[i+1].rgb;
        end

        // ---- asynchronous reset takes effect before any edge ----
        rstB_n = 1'b0;
        #1;
        check_obs("async_rst_B", obsB, RST_OBS);
        repeat (2) @(negedge clk);

        // ---- long randomized run on both instances ----
        hs_low_cnt = 0; bn_hi_cnt = 0; first_hs_x = -1;
        rise_found = 1'b0; rise_x = -1; rise_rgb = -1;
        prev_bnA = 1'b0;
        @(negedge clk);
        rstA_n = 1'b1;
        rstB_n = 1'b1;
        for (int k = 0; k < RUN_K; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            check_obs($sformatf("A_cyc%0d", k), obsA, model(DIV_A, DLY_A, k));
            check_obs($sformatf("B_cyc%0d", k), obsB, model(DIV_B, DLY_B, k));
            if (k >= 1 && k <= 800) begin
                if (!hsB) begin
                    hs_low_cnt++;
                    if (first_hs_x < 0) first_hs_x = int'(xB);
                end
                if (bnB) bn_hi_cnt++;
            end
            if (k >= 1600 && !rise_found && !prev_bnA && bnA) begin
                rise_found = 1'b1;
                rise_x     = int'(xA);
                rise_rgb   = int'({rA, gA, bA});
            end
            prev_bnA = bnA;
            rgbA = drive_rgb(DIV_A, DLY_A, k);
            rgbB = drive_rgb(DIV_B, DLY_B, k);
            if (n_checks - n_pass > 30) break;
        end
        check_int("B_hsync_low_pixels", hs_low_cnt, 96);
        check_int("B_hsync_first_x", first_hs_x, 657);
        check_int("B_blankN_high_pixels", bn_hi_cnt, 640);
        check_int("A_line1_rise_found", int'(rise_found), 1);
        check_int("A_line1_rise_x", rise_x, 3);
        check_int("A_line1_rise_rgb", rise_rgb, 12'hFFF);

        // ---- mid-line reset of instance A, then restart from (0,0) ----
        @(negedge clk);
        #1;
        check_int("A_pre_rst_x", int'(xA), 300);
        rstA_n = 1'b0;
        #1;
        check_obs("A_midrst_now", obsA, RST_OBS);
        repeat (3) begin
            @(negedge clk);
            #1;
            check_obs("A_midrst_hold", obsA, RST_OBS);
        end
        @(negedge clk);
        rstA_n = 1'b1;
        for (int k = 0; k < POST_K; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            check_obs($sformatf("A_post%0d", k), obsA, model(DIV_A, DLY_A, k));
            rgbA = drive_rgb(DIV_A, DLY_A, k);
            if (n_checks - n_pass > 60) break;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
